// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: one-cycle read latency, store write buffer with
// byte-merged load forwarding, retiring into a single-port word array.
module data_sram_responder #(
    parameter int ADDR_W   = 10,
    parameter int WB_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      data_sram_en,
    input  logic [3:0]                data_sram_wen,
    input  logic [31:0]               data_sram_addr,
    input  logic [31:0]               data_sram_wdata,
    output logic [31:0]               data_sram_rdata,
    output logic [$clog2(WB_DEPTH):0] wb_count
);
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WORDS = 1 << ADDR_W;

    // Byte-lane merge: lanes with mask set take new_word, others keep old_word.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  mask);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

    logic [31:0]       mem [WORDS];

    logic [ADDR_W-1:0] wb_idx  [WB_DEPTH];
    logic [31:0]       wb_data [WB_DEPTH];
    logic [3:0]        wb_mask [WB_DEPTH];

    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;

    logic [ADDR_W-1:0] idx_p0;
    logic              is_read_p0;
    logic              is_write_p0;
    logic              wb_full;
    logic              wb_empty;
    logic              drain_p0;
    logic [31:0]       fwd_word_p0;
    logic [31:0]       rdata_p1;

    logic              unused_addr_bits;

    // Stage p0: request decode and single-port arbitration
    assign idx_p0      = data_sram_addr[ADDR_W+1:2];
    assign is_read_p0  = data_sram_en && (data_sram_wen == 4'b0000);
    assign is_write_p0 = data_sram_en && (data_sram_wen != 4'b0000);
    assign wb_full     = (count_q == CNT_W'(WB_DEPTH));
    assign wb_empty    = (count_q == '0);
    // A read owns the array port; a full-buffer write forces the oldest entry
    // out so the new store can be pushed without stalling.
    assign drain_p0    = !is_read_p0 &&
                         ((is_write_p0 && wb_full) || (!data_sram_en && !wb_empty));

    assign unused_addr_bits = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

    // Walk entries oldest to youngest so the youngest matching byte wins.
    always_comb begin
        fwd_word_p0 = mem[idx_p0];
        for (int k = 0; k < WB_DEPTH; k++) begin
            if ((CNT_W'(k) < count_q) &&
                (wb_idx[head_q + PTR_W'(k)] == idx_p0)) begin
                fwd_word_p0 = byte_merge(fwd_word_p0,
                                         wb_data[head_q + PTR_W'(k)],
                                         wb_mask[head_q + PTR_W'(k)]);
            end
        end
    end

    // Stage p1: array retire, buffer push, registered read data
    always_ff @(posedge clk) begin
        if (drain_p0) begin
            mem[wb_idx[head_q]] <= byte_merge(mem[wb_idx[head_q]],
                                              wb_data[head_q],
                                              wb_mask[head_q]);
        end
    end

    always_ff @(posedge clk) begin
        if (is_write_p0) begin
            wb_idx[tail_q]  <= idx_p0;
            wb_data[tail_q] <= data_sram_wdata;
            wb_mask[tail_q] <= data_sram_wen;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            rdata_p1 <= '0;
        end else begin
            if (is_write_p0) tail_q <= tail_q + PTR_W'(1);
            if (drain_p0)    head_q <= head_q + PTR_W'(1);
            case ({is_write_p0, drain_p0})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (is_read_p0) rdata_p1 <= fwd_word_p0;
        end
    end

    assign data_sram_rdata = rdata_p1;
    assign wb_count        = count_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed table-driven bench for data_sram_responder (ADDR_W=10, WB_DEPTH=4).
module tb_data_sram_responder;

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_count;
    } vec_t;

    logic        clk;
    logic        resetn;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic [2:0]  wb_count;

    int n_checks;
    int n_fail;
    vec_t vecs[$];

    data_sram_responder #(.ADDR_W(10), .WB_DEPTH(4)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .wb_count        (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void add(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                input int exp_count);
        vec_t v;
        v.en = en; v.wen = wen; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_count = exp_count;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                         input logic [31:0] wdata);
        data_sram_en    = en;
        data_sram_wen   = wen;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        drive(1'b0, 4'h0, 32'h0, 32'h0);

        // Forwarding then array read-back
        add(1, 4'hF, 32'h10, 32'h11223344, 32'h00000000, 1);
        add(1, 4'h0, 32'h10, 32'h0,        32'h11223344, 1);
        add(0, 4'h0, 32'h0,  32'h0,        32'h11223344, 0);
        add(1, 4'h0, 32'h10, 32'h0,        32'h11223344, 0);
        // Byte merge over drained word
        add(1, 4'hF, 32'h10, 32'hAABBCCDD, 32'h11223344, 1);
        add(0, 4'h0, 32'h0,  32'h0,        32'h11223344, 0);
        add(1, 4'h1, 32'h10, 32'h000000EE, 32'h11223344, 1);
        add(1, 4'h2, 32'h10, 32'h0000FF00, 32'h11223344, 2);
        add(1, 4'h0, 32'h10, 32'h0,        32'hAABBFFEE, 2);
        add(0, 4'h0, 32'h0,  32'h0,        32'hAABBFFEE, 1);
        add(0, 4'h0, 32'h0,  32'h0,        32'hAABBFFEE, 0);
        add(1, 4'h0, 32'h10, 32'h0,        32'hAABBFFEE, 0);
        // Full buffer: forced drains keep occupancy at 4
        for (int i = 0; i < 6; i++)
            add(1, 4'hF, 32'(i * 4), 32'(i) * 32'h01010101, 32'hAABBFFEE, (i < 4) ? i + 1 : 4);
        for (int i = 0; i < 6; i++)
            add(1, 4'h0, 32'(i * 4), 32'h0, 32'(i) * 32'h01010101, 4);
        for (int i = 0; i < 4; i++)
            add(0, 4'h0, 32'h0, 32'h0, 32'h05050505, 3 - i);
        for (int i = 0; i < 6; i++)
            add(1, 4'h0, 32'(i * 4), 32'h0, 32'(i) * 32'h01010101, 0);
        // Reads own the port: no drain during back-to-back reads
        add(1, 4'hF, 32'h18, 32'h66666666, 32'h05050505, 1);
        add(1, 4'hF, 32'h1C, 32'h77777777, 32'h05050505, 2);
        add(1, 4'h0, 32'h18, 32'h0,        32'h66666666, 2);
        add(1, 4'h0, 32'h1C, 32'h0,        32'h77777777, 2);
        add(1, 4'h0, 32'h18, 32'h0,        32'h66666666, 2);
        add(0, 4'h0, 32'h0,  32'h0,        32'h66666666, 1);
        add(0, 4'h0, 32'h0,  32'h0,        32'h66666666, 0);
        // Aliasing: upper address bits ignored
        add(1, 4'hF, 32'h00000004, 32'hCAFEF00D, 32'h66666666, 1);
        add(1, 4'h0, 32'h00001004, 32'h0,        32'hCAFEF00D, 1);
        add(0, 4'h0, 32'h0,        32'h0,        32'hCAFEF00D, 0);
        add(1, 4'h0, 32'h00001004, 32'h0,        32'hCAFEF00D, 0);
        // Youngest entry wins per byte
        add(1, 4'hF, 32'h20, 32'h11111111, 32'hCAFEF00D, 1);
        add(1, 4'h3, 32'h20, 32'h22222222, 32'hCAFEF00D, 2);
        add(1, 4'h6, 32'h20, 32'h33333333, 32'hCAFEF00D, 3);
        add(1, 4'h0, 32'h20, 32'h0,        32'h11333322, 3);

        repeat (2) @(posedge clk);
        #1;
        check("reset_rdata", data_sram_rdata, 32'h0);
        check("reset_count", 32'(wb_count), 32'h0);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_rdata", i), data_sram_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_count", i), 32'(wb_count), 32'(vecs[i].exp_count));
        end

        // Asynchronous reset mid-cycle with 3 pending entries
        drive(1'b1, 4'h0, 32'h20, 32'h0);
        #3;
        resetn = 1'b0;
        #1;
        check("async_rst_count", 32'(wb_count), 32'h0);
        check("async_rst_rdata", data_sram_rdata, 32'h0);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        drive(1'b1, 4'h0, 32'h300, 32'h0);
        @(posedge clk);
        #1;
        check("post_rst_count", 32'(wb_count), 32'h0);
        check("post_rst_count_known", 32'($isunknown(wb_count)), 32'h0);
        drive(1'b1, 4'hF, 32'h40, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        check("post_rst_write_count", 32'(wb_count), 32'h1);
        drive(1'b1, 4'h0, 32'h40, 32'h0);
        @(posedge clk);
        #1;
        check("post_rst_read", data_sram_rdata, 32'hDEADBEEF);
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        check("post_rst_drain_count", 32'(wb_count), 32'h0);
        check("post_rst_hold_rdata", data_sram_rdata, 32'hDEADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
